data_mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the 128-byte, big-endian, 3-byte-word data memory.
- Port 0 serves the CPU load/store path; port 1 serves a secondary master (loader/debug/DMA).
- Grants one access at a time with round-robin fairness and drives the memory's address, data and strobes.
- Returns registered read data and a completion pulse to the granted requester.

---
 rtl/data_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module      : data_mem_arbiter
// Description : Two-port round-robin arbiter and access sequencer in front of
//               the 128-byte big-endian 3-byte-word data memory. Port 0 is
//               the CPU load/store path, port 1 a secondary master. Each
//               access runs IDLE -> ACCESS -> RESP. Optional address bounds
//               checking is enabled by defining MEM_BOUNDS_CHECK_EN.
// Revision    : 1.0 - initial release
//============================================================================
module data_mem_arbiter #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 24,
    parameter int MEM_BYTES  = 128
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    // requester port 0 (CPU)
    input  logic                  Req0Valid,
    output logic                  Req0Ready,
    input  logic                  Req0Write,
    input  logic [ADDR_WIDTH-1:0] Req0Addr,
    input  logic [DATA_WIDTH-1:0] Req0WData,
    output logic                  Req0Done,
    output logic [DATA_WIDTH-1:0] Req0RData,
    output logic                  Req0Err,
    // requester port 1 (secondary master)
    input  logic                  Req1Valid,
    output logic                  Req1Ready,
    input  logic                  Req1Write,
    input  logic [ADDR_WIDTH-1:0] Req1Addr,
    input  logic [DATA_WIDTH-1:0] Req1WData,
    output logic                  Req1Done,
    output logic [DATA_WIDTH-1:0] Req1RData,
    output logic                  Req1Err,
    // memory side
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] MemReadData
);

    // Highest byte address at which a full 3-byte word still fits.
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(MEM_BYTES - 3);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_last_grant;
    logic                  r_port;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata0;
    logic [DATA_WIDTH-1:0] r_rdata1;

    logic                  w_accept;
    logic                  w_grant_port;
    logic                  w_oob_cmp;
    logic                  w_oob;
    logic [DATA_WIDTH-1:0] w_resp_word;

    // Full-width compare so large addresses never alias back into range.
    assign w_oob_cmp = (r_addr > c_LAST_ADDR);

`ifdef MEM_BOUNDS_CHECK_EN
    assign w_oob = w_oob_cmp;
`else
    logic w_unused_oob;
    assign w_oob        = 1'b0;
    assign w_unused_oob = w_oob_cmp;
`endif

    // Word returned to the requester: loads only, and only when in range.
    assign w_resp_word = (r_write || w_oob) ? '0 : MemReadData;

    // Memory bus always presents the latched transaction; strobes qualify it.
    assign MemAddress   = r_addr;
    assign MemWriteData = r_wdata;
    assign Req0RData    = r_rdata0;
    assign Req1RData    = r_rdata1;

    // State register; reset forces IDLE so an in-flight strobe drops at once.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, arbitration and strobe/handshake decode.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_grant_port = 1'b0;
        Req0Ready    = 1'b0;
        Req1Ready    = 1'b0;
        Req0Done     = 1'b0;
        Req1Done     = 1'b0;
        Req0Err      = 1'b0;
        Req1Err      = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Under contention the port that did not win last time goes.
                if (Req0Valid && Req1Valid) begin
                    w_grant_port = ~r_last_grant;
                end else begin
                    w_grant_port = Req1Valid;
                end
                // Handshake is held off while reset is asserted.
                if ((Req0Valid || Req1Valid) && Reset_n) begin
                    w_accept     = 1'b1;
                    Req0Ready    = ~w_grant_port;
                    Req1Ready    = w_grant_port;
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                MemWrite     = r_write && !w_oob;
                MemRead      = !r_write && !w_oob;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                Req0Done     = ~r_port;
                Req1Done     = r_port;
                Req0Err      = ~r_port && w_oob;
                Req1Err      = r_port && w_oob;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Latch the winning request and remember who won for round-robin.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_port;
            r_port       <= w_grant_port;
            r_write      <= w_grant_port ? Req1Write : Req0Write;
            r_addr       <= w_grant_port ? Req1Addr  : Req0Addr;
            r_wdata      <= w_grant_port ? Req1WData : Req0WData;
        end
    end

    // Capture the response word for the granted port at the end of ACCESS;
    // the other port's read data is left untouched.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == S_ACCESS) begin
            if (r_port) begin
                r_rdata1 <= w_resp_word;
            end else begin
                r_rdata0 <= w_resp_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_data_mem_arbiter
// Description : Scoreboard bench for data_mem_arbiter with a byte-array
//               memory model. Expected completions are queued at grant time
//               and checked by an independent Done monitor.
// Revision    : 1.0 - initial release
//============================================================================
module tb_data_mem_arbiter;

    logic        Clock;
    logic        Reset_n;
    logic        Req0Valid, Req0Ready, Req0Write, Req0Done, Req0Err;
    logic [23:0] Req0Addr, Req0WData, Req0RData;
    logic        Req1Valid, Req1Ready, Req1Write, Req1Done, Req1Err;
    logic [23:0] Req1Addr, Req1WData, Req1RData;
    logic [23:0] MemAddress, MemWriteData, MemReadData;
    logic        MemWrite, MemRead;

    data_mem_arbiter #(.ADDR_WIDTH(24), .DATA_WIDTH(24), .MEM_BYTES(128)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Write(Req0Write),
        .Req0Addr(Req0Addr), .Req0WData(Req0WData), .Req0Done(Req0Done),
        .Req0RData(Req0RData), .Req0Err(Req0Err),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Write(Req1Write),
        .Req1Addr(Req1Addr), .Req1WData(Req1WData), .Req1Done(Req1Done),
        .Req1RData(Req1RData), .Req1Err(Req1Err),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
    );

    typedef struct {
        int          port;
        logic [23:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic [7:0]  mem [0:255];
    bit          mem_init_done = 1'b0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Memory model: big-endian, combinational read, write on rising edge.
    // Contents are seeded with i ^ 8'h5A on the first edge under reset.
    always @(posedge Clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_init_done <= 1'b1;
        end else if (MemWrite) begin
            mem[MemAddress[7:0]]         <= MemWriteData[23:16];
            mem[MemAddress[7:0] + 8'd1]  <= MemWriteData[15:8];
            mem[MemAddress[7:0] + 8'd2]  <= MemWriteData[7:0];
        end
    end

    always_comb begin
        MemReadData = {mem[MemAddress[7:0]], mem[MemAddress[7:0] + 8'd1],
                       mem[MemAddress[7:0] + 8'd2]};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completion monitor: pops one expectation per Done pulse.
    always @(negedge Clock) begin
        if (Req0Done || Req1Done) begin
            if (q.size() == 0) begin
                check("unexpected_done", {Req0Done, Req1Done}, 2'b00);
            end else begin
                mon_e = q.pop_front();
                check("done_port", {Req0Done, Req1Done}, (mon_e.port == 0) ? 2'b10 : 2'b01);
                check("done_rdata", (mon_e.port == 0) ? Req0RData : Req1RData, mon_e.rd);
                check("done_err", {Req0Err, Req1Err},
                      (mon_e.port == 0) ? {mon_e.err, 1'b0} : {1'b0, mon_e.err});
                check("done_latency", cyc, mon_e.cyc);
            end
        end
    end

    // Waits (bounded) for a Ready; port = 2 if both rise, -1 on timeout.
    task automatic wait_ready(output int port, output int k);
        port = -1;
        k    = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (Req0Ready || Req1Ready) begin
                port = (Req0Ready && Req1Ready) ? 2 : (Req1Ready ? 1 : 0);
                k    = cyc;
                break;
            end
            @(negedge Clock);
        end
        if (port < 0) check("ready_timeout", 64'd0, 64'd1);
    endtask

    // Expects a grant to exp_port, queues the completion, and checks the
    // ACCESS and RESP cycles on the memory side. Returns at the RESP negedge.
    task automatic expect_grant(input int exp_port, input logic wr, input logic [23:0] a,
                                input logic [23:0] wd, input logic [23:0] exp_rd,
                                input logic exp_err, input logic strobe, input logic drop,
                                output int k);
        int p;
        wait_ready(p, k);
        check("grant_port", 64'(p), 64'(exp_port));
        q.push_back(exp_t'{port: exp_port, rd: exp_rd, err: exp_err, cyc: k + 2});
        @(negedge Clock);
        check("access_strobes", {Req0Ready, Req1Ready, MemWrite, MemRead},
              {2'b00, wr & strobe, ~wr & strobe});
        check("access_addr", MemAddress, a);
        if (wr) check("access_wdata", MemWriteData, wd);
        if (drop) begin
            if (exp_port == 0) Req0Valid = 1'b0;
            else               Req1Valid = 1'b0;
        end
        @(negedge Clock);
        check("resp_strobes", {Req0Ready, Req1Ready, MemWrite, MemRead}, 4'b0000);
    endtask

    task automatic set0(input logic v, input logic w, input logic [23:0] a, input logic [23:0] d);
        Req0Valid = v; Req0Write = w; Req0Addr = a; Req0WData = d;
    endtask

    task automatic set1(input logic v, input logic w, input logic [23:0] a, input logic [23:0] d);
        Req1Valid = v; Req1Write = w; Req1Addr = a; Req1WData = d;
    endtask

    function automatic logic [23:0] mem_word(input int a);
        return {mem[a], mem[a + 1], mem[a + 2]};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k0, k1, k2, k3, p;
        Reset_n = 1'b0;
        set0(1'b0, 1'b0, 24'h0, 24'h0);
        set1(1'b0, 1'b0, 24'h0, 24'h0);

        // Reset with random requester inputs: everything stays quiet.
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            set0(1'($urandom), 1'($urandom), 24'($urandom), 24'($urandom));
            set1(1'($urandom), 1'($urandom), 24'($urandom), 24'($urandom));
            #1;
            check("reset_ctrl", {Req0Ready, Req1Ready, Req0Done, Req1Done,
                                 Req0Err, Req1Err, MemWrite, MemRead}, 8'h00);
            check("reset_rdata", {Req0RData, Req1RData}, 48'h0);
            check("reset_membus", {MemAddress, MemWriteData}, 48'h0);
        end

        // Release; port 0 store 0x10 = A1B2C3.
        @(negedge Clock);
        set1(1'b0, 1'b0, 24'h0, 24'h0);
        set0(1'b1, 1'b1, 24'h000010, 24'hA1B2C3);
        Reset_n = 1'b1;
        expect_grant(0, 1'b1, 24'h000010, 24'hA1B2C3, 24'h0, 1'b0, 1'b1, 1'b1, k0);
        check("store_bytes_16_18", mem_word(16), 24'hA1B2C3);

        // Port 1 load of the same word.
        set1(1'b1, 1'b0, 24'h000010, 24'h0);
        expect_grant(1, 1'b0, 24'h000010, 24'h0, 24'hA1B2C3, 1'b0, 1'b1, 1'b1, k0);

        // Port 1 unaligned load 0x11: B2, C3, then seed byte 0x13^0x5A.
        set1(1'b1, 1'b0, 24'h000011, 24'h0);
        expect_grant(1, 1'b0, 24'h000011, 24'h0, 24'hB2C349, 1'b0, 1'b1, 1'b1, k0);

        // Contention: last grant was port 1, so order is 0,1,0,1.
        set0(1'b1, 1'b1, 24'h000040, 24'h112233);
        set1(1'b1, 1'b0, 24'h000040, 24'h0);
        expect_grant(0, 1'b1, 24'h000040, 24'h112233, 24'h0, 1'b0, 1'b1, 1'b0, k0);
        Req0WData = 24'h445566;
        expect_grant(1, 1'b0, 24'h000040, 24'h0, 24'h112233, 1'b0, 1'b1, 1'b0, k1);
        expect_grant(0, 1'b1, 24'h000040, 24'h445566, 24'h0, 1'b0, 1'b1, 1'b1, k2);
        check("rdata1_hold", Req1RData, 24'h112233);
        expect_grant(1, 1'b0, 24'h000040, 24'h0, 24'h445566, 1'b0, 1'b1, 1'b1, k3);
        check("contention_spacing", 64'({k1 - k0, k2 - k1, k3 - k2}), 64'({32'd3, 32'd3, 32'd3}));

        // Reset during ACCESS of a store: strobe drops at once, no Done.
        set0(1'b1, 1'b1, 24'h000020, 24'hFFFFFF);
        wait_ready(p, k0);
        check("midreset_grant", 64'(p), 64'd0);
        @(negedge Clock);
        check("midreset_memwrite_before", MemWrite, 1'b1);
        Req0Valid = 1'b0;
        #1 Reset_n = 1'b0;
        #1;
        check("midreset_strobes_after", {MemWrite, MemRead}, 2'b00);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        check("midreset_bytes_32_34", mem_word(32), 24'h7A7B78);
        check("midreset_queue_empty", 64'(q.size()), 64'd0);

        // After reset port 0 wins contention again.
        set0(1'b1, 1'b0, 24'h000020, 24'h0);
        set1(1'b1, 1'b0, 24'h000010, 24'h0);
        expect_grant(0, 1'b0, 24'h000020, 24'h0, 24'h7A7B78, 1'b0, 1'b1, 1'b1, k0);
        expect_grant(1, 1'b0, 24'h000010, 24'h0, 24'hA1B2C3, 1'b0, 1'b1, 1'b1, k1);

`ifdef MEM_BOUNDS_CHECK_EN
        // 0x7E is past the last full word: no strobe, Err, memory unchanged.
        set0(1'b1, 1'b1, 24'h00007E, 24'h0BADF0);
        expect_grant(0, 1'b1, 24'h00007E, 24'h0BADF0, 24'h0, 1'b1, 1'b0, 1'b1, k0);
        check("oob_bytes_126_128", mem_word(126), 24'h2425DA);
        set0(1'b1, 1'b0, 24'h800010, 24'h0);
        expect_grant(0, 1'b0, 24'h800010, 24'h0, 24'h0, 1'b1, 1'b0, 1'b1, k0);
`else
        // No check: 0x7E goes straight to memory.
        set0(1'b1, 1'b1, 24'h00007E, 24'h0BADF0);
        expect_grant(0, 1'b1, 24'h00007E, 24'h0BADF0, 24'h0, 1'b0, 1'b1, 1'b1, k0);
        check("nochk_bytes_126_128", mem_word(126), 24'h0BADF0);
`endif
        // 0x7D is the last legal word address.
        set0(1'b1, 1'b1, 24'h00007D, 24'h123456);
        expect_grant(0, 1'b1, 24'h00007D, 24'h123456, 24'h0, 1'b0, 1'b1, 1'b1, k0);
        check("edge_bytes_125_127", mem_word(125), 24'h123456);

        repeat (4) @(negedge Clock);
        check("final_queue_empty", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
